// File: rtl/opl_pkg.sv
`default_nettype none
// ============================================================================
// opl_pkg : shared types and constants for the OPL3 bus initiator
// Rev 1.0
// ============================================================================
package opl_pkg;

  typedef logic [3:0] opl_state_t;

  localparam opl_state_t ST_IDLE     = 4'd0;
  localparam opl_state_t ST_W_ASETUP = 4'd1;
  localparam opl_state_t ST_W_ASTB   = 4'd2;
  localparam opl_state_t ST_W_AHOLD  = 4'd3;
  localparam opl_state_t ST_W_DSETUP = 4'd4;
  localparam opl_state_t ST_W_DSTB   = 4'd5;
  localparam opl_state_t ST_W_DWAIT  = 4'd6;
  localparam opl_state_t ST_R_SETUP  = 4'd7;
  localparam opl_state_t ST_R_STB    = 4'd8;
  localparam opl_state_t ST_R_DONE   = 4'd9;

  // 'reg' is a keyword, so the register-number field is reg_no
  typedef struct packed {
    logic       rd;
    logic [7:0] reg_no;
    logic [7:0] data;
  } opl_cmd_t;

  localparam logic OPL_ADDR_PORT = 1'b0;
  localparam logic OPL_DATA_PORT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/opl_bus_master_if.sv
`default_nettype none
// ============================================================================
// opl_bus_master_if : command/response handshake and OPL chip-side bus
// Rev 1.0
// ============================================================================
interface opl_bus_master_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       opl_addr;
  logic [7:0] opl_din;
  logic       opl_we;
  logic       opl_rd;
  logic [7:0] opl_dout;
  logic       opl_irq_n;
  logic       irq;

  modport master (
    input  cmd_valid, cmd_rd, cmd_reg, cmd_data, opl_dout, opl_irq_n,
    output cmd_ready, rsp_valid, rsp_data, busy,
    output opl_addr, opl_din, opl_we, opl_rd, irq
  );

  modport slave (
    output cmd_valid, cmd_rd, cmd_reg, cmd_data, opl_dout, opl_irq_n,
    input  cmd_ready, rsp_valid, rsp_data, busy,
    input  opl_addr, opl_din, opl_we, opl_rd, irq
  );

endinterface
`default_nettype wire

// File: rtl/opl_cmd_fifo.sv
`default_nettype none
// ============================================================================
// opl_cmd_fifo : synchronous command queue with registered read data
// Rev 1.0
// ============================================================================
module opl_cmd_fifo
  import opl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clk_opl,
  input  logic     rst_n,
  input  logic     push,
  input  opl_cmd_t push_data,
  input  logic     pop,
  output opl_cmd_t pop_data,
  output logic     head_rd,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_full_cnt = (PTR_W + 1)'(DEPTH);

  opl_cmd_t         r_mem [DEPTH];
  opl_cmd_t         r_pop_data;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == c_full_cnt);
  assign empty   = (r_count == '0);
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign pop_data = r_pop_data;
  // Lets the FSM pick the read or write path on the same edge it pops
  assign head_rd = r_mem[r_rptr].rd;

  always_ff @(posedge clk_opl) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk_opl) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_pop_data <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_pop_data <= r_mem[r_rptr];
        r_rptr     <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/opl_bus_master.sv
`default_nettype none
// ============================================================================
// opl_bus_master : queues OPL3 register writes / status reads and replays
//                  them as timed address/data strobe cycles; syncs the IRQ
// Rev 1.0
// ============================================================================
module opl_bus_master
  import opl_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int STROBE_CYC = 2,
  parameter int ADDR_WAIT  = 6,
  parameter int DATA_WAIT  = 36
) (
  input  logic             clk_opl,
  input  logic             rst_n,
  opl_bus_master_if.master bus
);

  localparam int CNT_MAX_AS = (STROBE_CYC > ADDR_WAIT) ? STROBE_CYC : ADDR_WAIT;
  localparam int CNT_MAX    = (CNT_MAX_AS > DATA_WAIT) ? CNT_MAX_AS : DATA_WAIT;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_stb_ld   = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] c_await_ld = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] c_dwait_ld = CNT_W'(DATA_WAIT - 1);

  opl_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_opl_addr;
  logic [7:0]       r_opl_din;
  logic             r_opl_we;
  logic             r_opl_rd;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;
  logic             r_irq_meta;
  logic             r_irq;

  opl_cmd_t         w_push_cmd;
  opl_cmd_t         w_cmd;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_head_rd;
  logic             w_cnt_zero;
  logic             w_unused_rd;

  assign w_push_cmd  = '{rd: bus.cmd_rd, reg_no: bus.cmd_reg, data: bus.cmd_data};
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_unused_rd = w_cmd.rd;

  opl_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_opl   (clk_opl),
    .rst_n     (rst_n),
    .push      (bus.cmd_valid),
    .push_data (w_push_cmd),
    .pop       (w_pop),
    .pop_data  (w_cmd),
    .head_rd   (w_head_rd),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Strobe/response registers decode the current state, so every bus output
  // trails the state register by one edge and stays glitch-free.
  always_ff @(posedge clk_opl) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_opl_addr  <= OPL_ADDR_PORT;
      r_opl_din   <= '0;
      r_opl_we    <= 1'b0;
      r_opl_rd    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_opl_we    <= (r_state == ST_W_ASTB) || (r_state == ST_W_DSTB);
      r_opl_rd    <= (r_state == ST_R_STB);
      r_rsp_valid <= (r_state == ST_R_DONE);

      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state <= w_head_rd ? ST_R_SETUP : ST_W_ASETUP;
          end
        end
        ST_W_ASETUP: begin
          r_opl_addr <= OPL_ADDR_PORT;
          r_opl_din  <= w_cmd.reg_no;
          r_cnt      <= c_stb_ld;
          r_state    <= ST_W_ASTB;
        end
        ST_W_ASTB: begin
          if (w_cnt_zero) begin
            r_cnt   <= c_await_ld;
            r_state <= ST_W_AHOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_W_AHOLD: begin
          if (w_cnt_zero) begin
            r_state <= ST_W_DSETUP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_W_DSETUP: begin
          r_opl_addr <= OPL_DATA_PORT;
          r_opl_din  <= w_cmd.data;
          r_cnt      <= c_stb_ld;
          r_state    <= ST_W_DSTB;
        end
        ST_W_DSTB: begin
          if (w_cnt_zero) begin
            r_cnt   <= c_dwait_ld;
            r_state <= ST_W_DWAIT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_W_DWAIT: begin
          if (w_cnt_zero) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_R_SETUP: begin
          r_opl_addr <= OPL_ADDR_PORT;
          r_cnt      <= c_stb_ld;
          r_state    <= ST_R_STB;
        end
        ST_R_STB: begin
          if (w_cnt_zero) begin
            r_state <= ST_R_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_R_DONE: begin
          // This edge closes the last cycle with opl_rd high
          r_rsp_data <= bus.opl_dout;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_opl) begin
    if (!rst_n) begin
      r_irq_meta <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_meta <= ~bus.opl_irq_n;
      r_irq      <= r_irq_meta;
    end
  end

  assign bus.cmd_ready = !w_full;
  assign bus.busy      = (r_state != ST_IDLE) || !w_empty;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.opl_addr  = r_opl_addr;
  assign bus.opl_din   = r_opl_din;
  assign bus.opl_we    = r_opl_we;
  assign bus.opl_rd    = r_opl_rd;
  assign bus.irq       = r_irq;

endmodule
`default_nettype wire
